pop_count_pipe: RTL

// - Parametrised, pipelined population counter for census vectors.
// - Sits between the census transform and the disparity cost stage.
// - Generalises the single-register SWAR counter in three ways:
//   - widths up to 1024 bits;
//   - configurable pipeline register spacing;
//   - a valid signal that travels alongside the data.
// - Output is full-range: all-ones input is representable.

---
 rtl/pop_count_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/pop_count_pipe.sv
// Pipelined SWAR population counter; the valid bit travels beside the data, LAT = ceil(LEVELS/REG_EVERY) enabled edges.
// en=0 freezes every stage. Optional macro POP_COUNT_XOR_EN adds inp_b and counts inp ^ inp_b (Hamming distance).
module pop_count_pipe #(
  parameter int WIDTH     = 49,
  parameter int REG_EVERY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           inp,
`ifdef POP_COUNT_XOR_EN
  input  logic [WIDTH-1:0]           inp_b,
`endif
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] outp
);

  localparam int LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam int OUT_W  = $clog2(WIDTH + 1);
  localparam int LAT    = (REG_EVERY < 1) ? 1 : (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int P      = 1 << LEVELS;

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("pop_count_pipe: WIDTH=%0d outside 1..1024", WIDTH);
  end
  if (REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_bad_reg_every
    $error("pop_count_pipe: REG_EVERY=%0d outside 1..%0d", REG_EVERY, LEVELS);
  end

  // Low half of every 2^(k+1)-bit field set: selects the 2^k-bit operands of level k.
  function automatic logic [P-1:0] swar_mask(input int k);
    logic [P-1:0] m;
    m = '0;
    for (int i = 0; i < P; i++) begin
      m[i] = (((i >> k) & 1) == 0);
    end
    return m;
  endfunction

  logic [WIDTH-1:0] w_vec;
`ifdef POP_COUNT_XOR_EN
  assign w_vec = inp ^ inp_b;
`else
  assign w_vec = inp;
`endif

  logic [P-1:0] w_pad;
  always_comb begin
    w_pad              = '0;
    w_pad[WIDTH-1:0]   = w_vec;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam logic [P-1:0] MASK = swar_mask(k);
    localparam int           SH   = 1 << k;

    logic [P-1:0] w_in;
    logic [P-1:0] w_sum;
    logic [P-1:0] w_out;

    if (k == 0) begin : g_src
      assign w_in = w_pad;
    end else begin : g_chain
      assign w_in = g_lvl[k-1].w_out;
    end

    assign w_sum = (w_in & MASK) + ((w_in >> SH) & MASK);

    // The last level is always registered, but into the narrow outp register below.
    if (k == LEVELS - 1) begin : g_last
      assign w_out = w_sum;
    end else if (((k + 1) % REG_EVERY) == 0) begin : g_reg
      logic [P-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (en) begin
          r_q <= w_sum;
        end
      end
      assign w_out = r_q;
    end else begin : g_comb
      assign w_out = w_sum;
    end
  end

  logic [P-1:0]     w_top;
  logic [OUT_W-1:0] r_outp;
  logic [LAT-1:0]   r_vld;

  assign w_top = g_lvl[LEVELS-1].w_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outp <= '0;
      r_vld  <= '0;
    end else if (en) begin
      r_outp   <= OUT_W'(w_top);
      r_vld[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign outp      = r_outp;
  assign out_valid = r_vld[LAT-1];

endmodule
